// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle between a pipeline stage and its neighbours: upstream beat,
// downstream head, squash and occupancy.
interface pipe_stage_hs_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready back-pressure, flush squash and an
// optional skid entry that makes in_ready a flop.
//
//  state | meaning
//  EMPTY | no entry held, out_valid=0
//  ONE   | head in main register
//  TWO   | head in main, second beat in skid register, in_ready=0 (SKID=1 only)
module pipe_stage_hs #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter bit SKID   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pipe_stage_hs_if.slave  hs_io
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q, ready_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = SKID ? ready_q : (!out_valid || hs_io.out_ready);
  assign accept    = hs_io.in_valid && in_ready;
  assign pop       = out_valid && hs_io.out_ready;

  assign hs_io.in_ready  = in_ready;
  assign hs_io.out_valid = out_valid;
  assign hs_io.out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign hs_io.out_data  = main_data_q;
  assign hs_io.occupancy = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_ctrl_d = hs_io.in_ctrl;
          main_data_d = hs_io.in_data;
        end
      end
      ONE: begin
        if (accept && !pop && SKID) begin
          state_d     = TWO;
          skid_ctrl_d = hs_io.in_ctrl;
          skid_data_d = hs_io.in_data;
        end else if (accept && pop) begin
          main_ctrl_d = hs_io.in_ctrl;
          main_data_d = hs_io.in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Squash keeps the registers untouched so out_data holds its last head.
    if (hs_io.flush) begin
      state_d     = EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end

    ready_d = (state_d != TWO);
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Drives a SKID=1 stage (dut 0) and a SKID=0 stage (dut 1) side by side and
// compares them against a queue model of the stage.
module tb_pipe_stage_hs;

  logic clk;
  logic rst_n;

  logic        iv   [2];
  logic        fl   [2];
  logic        ordy [2];
  logic [7:0]  ic   [2];
  logic [63:0] idt  [2];
  logic        irdy [2];
  logic        ov   [2];
  logic [7:0]  oc   [2];
  logic [63:0] od   [2];
  logic [1:0]  occ  [2];

  int checks = 0;
  int errors = 0;

  logic [71:0] mq [2][$];
  logic [63:0] last_d [2];
  bit          pend [2];

  pipe_stage_hs_if #(.CTRL_W(8), .DATA_W(64)) hs0 ();
  pipe_stage_hs_if #(.CTRL_W(8), .DATA_W(64)) hs1 ();

  pipe_stage_hs #(.CTRL_W(8), .DATA_W(64), .SKID(1'b1)) u_skid1 (
    .clk_i (clk), .rst_ni(rst_n), .hs_io(hs0)
  );
  pipe_stage_hs #(.CTRL_W(8), .DATA_W(64), .SKID(1'b0)) u_skid0 (
    .clk_i (clk), .rst_ni(rst_n), .hs_io(hs1)
  );

  assign hs0.flush     = fl[0];
  assign hs0.in_valid  = iv[0];
  assign hs0.in_ctrl   = ic[0];
  assign hs0.in_data   = idt[0];
  assign hs0.out_ready = ordy[0];
  assign irdy[0] = hs0.in_ready;
  assign ov[0]   = hs0.out_valid;
  assign oc[0]   = hs0.out_ctrl;
  assign od[0]   = hs0.out_data;
  assign occ[0]  = hs0.occupancy;

  assign hs1.flush     = fl[1];
  assign hs1.in_valid  = iv[1];
  assign hs1.in_ctrl   = ic[1];
  assign hs1.in_data   = idt[1];
  assign hs1.out_ready = ordy[1];
  assign irdy[1] = hs1.in_ready;
  assign ov[1]   = hs1.out_valid;
  assign oc[1]   = hs1.out_ctrl;
  assign od[1]   = hs1.out_data;
  assign occ[1]  = hs1.occupancy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      last_d[d] = '0;
      pend[d]   = 1'b0;
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] c,
                        input logic [63:0] dt, input logic f, input logic r);
    iv[d] = v; ic[d] = c; idt[d] = dt; fl[d] = f; ordy[d] = r;
  endtask

  // One clock of both stages: ready/accept/pop from the model, then the
  // post-edge head compared with the model queue.
  task automatic clock_and_compare();
    bit          rdy [2];
    bit          acc [2];
    bit          pp  [2];
    logic [71:0] h;
    bit          ev;
    logic [7:0]  ec;
    #1;
    for (int d = 0; d < 2; d++) begin
      rdy[d] = (d == 0) ? (mq[d].size() < 2) : (mq[d].size() == 0 || ordy[d]);
      checks++;
      if (irdy[d] !== rdy[d]) begin
        errors++;
        $display("FAIL in_ready dut%0d t=%0t: got %b expected %b", d, $time, irdy[d], rdy[d]);
      end
      acc[d] = iv[d] && rdy[d];
      pp[d]  = (mq[d].size() > 0) && ordy[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fl[d]) mq[d].delete();
      else begin
        if (pp[d]) void'(mq[d].pop_front());
        if (acc[d]) mq[d].push_back({ic[d], idt[d]});
      end
      pend[d] = iv[d] && !acc[d] && !fl[d];
      if (mq[d].size() > 0) begin
        h = mq[d][0];
        last_d[d] = h[63:0];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      ev = (mq[d].size() > 0);
      ec = 8'h00;
      if (ev) begin
        h  = mq[d][0];
        ec = h[71:64];
      end
      checks++;
      if (ov[d] !== ev || oc[d] !== ec || od[d] !== last_d[d] || occ[d] !== 2'(mq[d].size())) begin
        errors++;
        $display("FAIL head dut%0d t=%0t: got v=%b c=%h d=%h occ=%0d expected v=%b c=%h d=%h occ=%0d",
                 d, $time, ov[d], oc[d], od[d], occ[d], ev, ec, last_d[d], mq[d].size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) set_in(d, 1'b1, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || oc[d] !== 8'h00 || od[d] !== 64'h0 || occ[d] !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got v=%b c=%h d=%h occ=%0d expected 0", d, ov[d], oc[d], od[d], occ[d]);
      end
      set_in(d, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (irdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, irdy[d]);
      end
    end
    clock_and_compare();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) set_in(d, 1'b1, 8'(i + 1), 64'h10 + 64'(i), 1'b0, 1'b1);
      clock_and_compare();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (od[d] !== 64'h10 + 64'(i) || occ[d] !== 2'd1) begin
          errors++;
          $display("FAIL stream dut%0d beat%0d: got d=%h occ=%0d expected d=%h occ=1", d, i, od[d], occ[d], 64'h10 + 64'(i));
        end
      end
    end
    for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    clock_and_compare();
  endtask

  task automatic test_skid_fill();
    logic [63:0] got [$];
    set_in(1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    set_in(0, 1'b1, 8'hB0, 64'h20, 1'b0, 1'b0);
    clock_and_compare();
    set_in(0, 1'b1, 8'hB1, 64'h21, 1'b0, 1'b0);
    clock_and_compare();
    checks++;
    if (irdy[0] !== 1'b0 || occ[0] !== 2'd2) begin
      errors++;
      $display("FAIL skid_full: got in_ready=%b occ=%0d expected in_ready=0 occ=2", irdy[0], occ[0]);
    end
    set_in(0, 1'b1, 8'hB2, 64'h22, 1'b0, 1'b0);
    clock_and_compare();
    clock_and_compare();
    ordy[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (ov[0] === 1'b1) got.push_back(od[0]);
      clock_and_compare();
      if (!pend[0]) iv[0] = 1'b0;
    end
    checks++;
    if (got.size() != 3 || got[0] !== 64'h20 || got[1] !== 64'h21 || got[2] !== 64'h22) begin
      errors++;
      $display("FAIL skid_drain_order: got %0d beats first=%h expected 20,21,22", got.size(),
               (got.size() > 0) ? got[0] : 64'hX);
    end
  endtask

  task automatic test_flush();
    set_in(0, 1'b1, 8'hC0, 64'h30, 1'b0, 1'b0);
    clock_and_compare();
    set_in(0, 1'b1, 8'hC1, 64'h31, 1'b0, 1'b0);
    clock_and_compare();
    set_in(0, 1'b1, 8'hC2, 64'h32, 1'b1, 1'b0);
    clock_and_compare();
    set_in(0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    checks++;
    if (ov[0] !== 1'b0 || oc[0] !== 8'h00 || occ[0] !== 2'd0) begin
      errors++;
      $display("FAIL flush_empty: got v=%b c=%h occ=%0d expected 0", ov[0], oc[0], occ[0]);
    end
    for (int k = 0; k < 3; k++) begin
      clock_and_compare();
      checks++;
      if (ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: got out_valid=%b data=%h expected 0", ov[0], od[0]);
      end
    end
  endtask

  task automatic test_skid0();
    set_in(0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    set_in(1, 1'b1, 8'hD0, 64'h40, 1'b0, 1'b0);
    clock_and_compare();
    set_in(1, 1'b1, 8'hD1, 64'h41, 1'b0, 1'b0);
    #1;
    checks++;
    if (irdy[1] !== 1'b0) begin
      errors++;
      $display("FAIL skid0_stall_ready: got %b expected 0", irdy[1]);
    end
    ordy[1] = 1'b1;
    #1;
    checks++;
    if (irdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL skid0_pass_ready: got %b expected 1", irdy[1]);
    end
    clock_and_compare();
    checks++;
    if (occ[1] !== 2'd1 || od[1] !== 64'h41 || oc[1] !== 8'hD1) begin
      errors++;
      $display("FAIL skid0_pop_accept: got occ=%0d d=%h c=%h expected occ=1 d=41 c=d1", occ[1], od[1], oc[1]);
    end
    iv[1] = 1'b0;
    clock_and_compare();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (!pend[d]) begin
          iv[d]  = ($urandom_range(0, 99) < 60);
          ic[d]  = 8'($urandom_range(1, 255));
          idt[d] = {$urandom, $urandom};
        end
        ordy[d] = ($urandom_range(0, 99) < 65);
        fl[d]   = ($urandom_range(0, 99) < 4);
      end
      clock_and_compare();
    end
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; fl[d] = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    for (int d = 0; d < 2; d++) set_in(d, 1'b1, 8'hE0, 64'h50, 1'b0, 1'b0);
    clock_and_compare();
    for (int d = 0; d < 2; d++) set_in(d, 1'b1, 8'hE1, 64'h51, 1'b0, 1'b0);
    clock_and_compare();
    checks++;
    if (occ[0] !== 2'd2) begin
      errors++;
      $display("FAIL async_prefill: got occ=%0d expected 2", occ[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || oc[d] !== 8'h00 || od[d] !== 64'h0 || occ[d] !== 2'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got v=%b c=%h d=%h occ=%0d expected 0", d, ov[d], oc[d], od[d], occ[d]);
      end
      set_in(d, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
    end
    #1 rst_n = 1'b1;
    model_clear();
    clock_and_compare();
    clock_and_compare();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) set_in(d, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
    model_clear();
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush();
    test_skid0();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
